// File: rtl/seven_seg_scan_display.sv
// seven_seg_scan_display: multi-digit seven-segment scan driver.
// Keeps a shift history of the last NUM_DIGITS key codes and time-multiplexes
// them onto one shared active-low segment bus with active-low anode enables.
// Optional feature macro: SSD_BLANK_EMPTY_EN (digits never written stay dark).
module seven_seg_scan_display #(
  parameter int NUM_DIGITS   = 2,
  parameter int REFRESH_DIV  = 24000,
  parameter int BLANK_CYCLES = 200
) (
  input  logic                  int_osc,
  input  logic                  reset,
  input  logic                  key_valid,
  input  logic [3:0]            key_code,
  input  logic                  clear,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an,
  output logic [2:0]            scan_idx
);

  localparam int              CNT_W     = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);
  localparam logic [2:0]       IDX_LAST  = 3'(NUM_DIGITS - 1);
  localparam logic [6:0]       SEG_OFF   = 7'b1111111;

  // Active-low abcdefg pattern for one hex digit.
  function automatic logic [6:0] decode(input logic [3:0] code);
    logic [6:0] pat;
    case (code)
      4'h0:    pat = 7'b0000001;
      4'h1:    pat = 7'b1001111;
      4'h2:    pat = 7'b0010010;
      4'h3:    pat = 7'b0000110;
      4'h4:    pat = 7'b1001100;
      4'h5:    pat = 7'b0100100;
      4'h6:    pat = 7'b0100000;
      4'h7:    pat = 7'b0001111;
      4'h8:    pat = 7'b0000000;
      4'h9:    pat = 7'b0001100;
      4'hA:    pat = 7'b0001000;
      4'hB:    pat = 7'b1100000;
      4'hC:    pat = 7'b0110001;
      4'hD:    pat = 7'b1000010;
      4'hE:    pat = 7'b0110000;
      default: pat = 7'b0111000;
    endcase
    return pat;
  endfunction

  logic [3:0]            hist [NUM_DIGITS];
  logic [CNT_W-1:0]      cnt;
  logic [2:0]            idx;
  logic [3:0]            cur_code;
  logic [6:0]            cur_seg;
  logic [NUM_DIGITS-1:0] cur_an;
`ifdef SSD_BLANK_EMPTY_EN
  logic [NUM_DIGITS-1:0] written;
  logic                  cur_written;
`endif

  // Key history: newest code enters digit 0, older codes move up, oldest falls off.
  always_ff @(posedge int_osc) begin
    if (reset || clear) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        hist[i] <= 4'h0;
      end
`ifdef SSD_BLANK_EMPTY_EN
      written <= '0;
`endif
    end else if (key_valid) begin
      hist[0] <= key_code;
      for (int i = 1; i < NUM_DIGITS; i++) begin
        hist[i] <= hist[i-1];
      end
`ifdef SSD_BLANK_EMPTY_EN
      written[0] <= 1'b1;
      for (int i = 1; i < NUM_DIGITS; i++) begin
        written[i] <= written[i-1];
      end
`endif
    end
  end

  // Slot timer: each digit owns REFRESH_DIV cycles, then the scan moves on.
  always_ff @(posedge int_osc) begin
    if (reset) begin
      cnt <= '0;
      idx <= 3'd0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Pick the digit under scan and build its anode mask and segment pattern.
  always_comb begin
    cur_code = 4'h0;
    cur_an   = '1;
`ifdef SSD_BLANK_EMPTY_EN
    cur_written = 1'b0;
`endif
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == 3'(i)) begin
        cur_code  = hist[i];
        cur_an[i] = 1'b0;
`ifdef SSD_BLANK_EMPTY_EN
        cur_written = written[i];
`endif
      end
    end
`ifdef SSD_BLANK_EMPTY_EN
    cur_seg = cur_written ? decode(cur_code) : SEG_OFF;
`else
    cur_seg = decode(cur_code);
`endif
  end

  // Registered pin drive; the start of every slot is dark so the previous digit cannot ghost.
  always_ff @(posedge int_osc) begin
    if (reset) begin
      seg      <= SEG_OFF;
      an       <= '1;
      scan_idx <= 3'd0;
    end else if (cnt < BLANK_END) begin
      seg      <= SEG_OFF;
      an       <= '1;
      scan_idx <= idx;
    end else begin
      seg      <= cur_seg;
      an       <= cur_an;
      scan_idx <= idx;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_display.sv
// tb_seven_seg_scan_display: three scan drivers of different sizes sharing one
// clock and reset, compared every cycle against an arithmetic model of the scan
// and history, plus hand-computed checkpoints.
module tb_seven_seg_scan_display;

  localparam int ND [3] = '{2, 4, 1};
  localparam int RD [3] = '{16, 8, 8};
  localparam int BD [3] = '{2, 2, 1};

  localparam logic [6:0] DEC [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

`ifdef SSD_BLANK_EMPTY_EN
  localparam logic [6:0] EMPTY = 7'b1111111;
`else
  localparam logic [6:0] EMPTY = 7'b0000001;
`endif

  logic       int_osc = 1'b0;
  logic       reset;
  logic       kv  [3];
  logic [3:0] kc  [3];
  logic       clr [3];

  logic [6:0] seg0, seg1, seg2;
  logic [1:0] an0;
  logic [3:0] an1;
  logic [0:0] an2;
  logic [2:0] si0, si1, si2;

  int         checks = 0;
  int         errors = 0;
  bit         seen   = 1'b0;
  int         cyc [3];
  logic [3:0] mh  [3][8];
  logic [3:0] mhp [3][8];
  bit         mf  [3][8];
  bit         mfp [3][8];

  seven_seg_scan_display #(.NUM_DIGITS(2), .REFRESH_DIV(16), .BLANK_CYCLES(2)) dut0 (
    .int_osc(int_osc), .reset(reset), .key_valid(kv[0]), .key_code(kc[0]),
    .clear(clr[0]), .seg(seg0), .an(an0), .scan_idx(si0));

  seven_seg_scan_display #(.NUM_DIGITS(4), .REFRESH_DIV(8), .BLANK_CYCLES(2)) dut1 (
    .int_osc(int_osc), .reset(reset), .key_valid(kv[1]), .key_code(kc[1]),
    .clear(clr[1]), .seg(seg1), .an(an1), .scan_idx(si1));

  seven_seg_scan_display #(.NUM_DIGITS(1), .REFRESH_DIV(8), .BLANK_CYCLES(1)) dut2 (
    .int_osc(int_osc), .reset(reset), .key_valid(kv[2]), .key_code(kc[2]),
    .clear(clr[2]), .seg(seg2), .an(an2), .scan_idx(si2));

  // Free-running system clock.
  always #5 int_osc = ~int_osc;

  task automatic checkOutput(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%b exp=%b", name, got, exp);
    end
  endtask

  task automatic applyStimulus(input int k, input logic v, input logic [3:0] code, input logic c);
    kv[k]  = v;
    kc[k]  = code;
    clr[k] = c;
  endtask

  // Advance the model of instance k by one clock edge, remembering the history it saw before the edge.
  task automatic modelEdge(input int k);
    for (int i = 0; i < 8; i++) begin
      mhp[k][i] = mh[k][i];
      mfp[k][i] = mf[k][i];
    end
    if (reset) begin
      seen   = 1'b1;
      cyc[k] = 0;
      for (int i = 0; i < 8; i++) begin
        mh[k][i] = 4'h0;
        mf[k][i] = 1'b0;
      end
    end else begin
      cyc[k]++;
      if (clr[k]) begin
        for (int i = 0; i < 8; i++) begin
          mh[k][i] = 4'h0;
          mf[k][i] = 1'b0;
        end
      end else if (kv[k]) begin
        for (int i = ND[k] - 1; i >= 1; i--) begin
          mh[k][i] = mh[k][i-1];
          mf[k][i] = mf[k][i-1];
        end
        mh[k][0] = kc[k];
        mf[k][0] = 1'b1;
      end
    end
  endtask

  // Outputs one edge after time position cyc reflect slot position cyc-1 and the older history.
  task automatic compareOne(input int k, input logic [6:0] gseg, input logic [7:0] gan,
                            input logic [2:0] gidx);
    logic [7:0] ean;
    logic [6:0] eseg;
    bit         lit;
    int         s, cnt, eidx;
    ean  = 8'hff;
    eseg = 7'b1111111;
    lit  = 1'b0;
    eidx = 0;
    if (cyc[k] > 0) begin
      s    = cyc[k] - 1;
      cnt  = s % RD[k];
      eidx = (s / RD[k]) % ND[k];
      if (cnt >= BD[k]) begin
        lit       = 1'b1;
        ean[eidx] = 1'b0;
`ifdef SSD_BLANK_EMPTY_EN
        eseg = mfp[k][eidx] ? DEC[mhp[k][eidx]] : EMPTY;
`else
        eseg = DEC[mhp[k][eidx]];
`endif
      end
    end
    checkOutput($sformatf("dut%0d seg @%0d", k, cyc[k]), {1'b0, gseg}, {1'b0, eseg});
    checkOutput($sformatf("dut%0d an @%0d", k, cyc[k]), gan, ean);
    checks++;
    if (!$onehot0(~gan)) begin
      errors++;
      $display("[TB] FAIL dut%0d onehot an @%0d got=%b exp=at most one low", k, cyc[k], gan);
    end
    if (lit) begin
      checkOutput($sformatf("dut%0d scan_idx @%0d", k, cyc[k]), {5'd0, gidx}, 8'(eidx));
    end
  endtask

  // One clock: model follows the edge, every instance is compared half a period later.
  task automatic step();
    @(posedge int_osc);
    for (int k = 0; k < 3; k++) begin
      modelEdge(k);
    end
    @(negedge int_osc);
    if (seen) begin
      compareOne(0, seg0, {6'h3f, an0}, si0);
      compareOne(1, seg1, {4'hf, an1}, si1);
      compareOne(2, seg2, {7'h7f, an2}, si2);
    end
  endtask

  task automatic stepTo(input int target);
    while (cyc[0] < target) begin
      step();
    end
  endtask

  // Directed sequence covering reset, history shifting, clear, full decode and mid-slot reset.
  initial begin
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(k, 1'b0, 4'h0, 1'b0);
      cyc[k] = 0;
      for (int i = 0; i < 8; i++) begin
        mh[k][i]  = 4'h0;
        mhp[k][i] = 4'h0;
        mf[k][i]  = 1'b0;
        mfp[k][i] = 1'b0;
      end
    end

    repeat (3) step();
    checkOutput("T1 an in reset", {6'h3f, an0}, 8'hff);
    checkOutput("T1 seg in reset", {1'b0, seg0}, 8'h7f);
    reset = 1'b0;
    step();
    checkOutput("T1 an blank 1", {6'h3f, an0}, 8'hff);
    step();
    checkOutput("T1 an blank 2", {6'h3f, an0}, 8'hff);
    step();
    checkOutput("T1 an first lit", {6'h3f, an0}, 8'hfe);
    checkOutput("T1 seg first lit", {1'b0, seg0}, {1'b0, EMPTY});
    checkOutput("T1 dut1 an first lit", {4'hf, an1}, 8'hfe);

    applyStimulus(0, 1'b1, 4'h3, 1'b0);
    step();
    applyStimulus(0, 1'b1, 4'hA, 1'b0);
    step();
    applyStimulus(0, 1'b0, 4'h0, 1'b0);
    step();
    checkOutput("T2 slot0 seg", {1'b0, seg0}, 8'b0000_1000);
    checkOutput("T2 slot0 an", {6'h3f, an0}, 8'hfe);
    stepTo(17);
    checkOutput("T2 slot1 blank an", {6'h3f, an0}, 8'hff);
    stepTo(19);
    checkOutput("T2 slot1 seg", {1'b0, seg0}, 8'b0000_0110);
    checkOutput("T2 slot1 an", {6'h3f, an0}, 8'hfd);
    stepTo(51);
    checkOutput("T2 repeat seg", {1'b0, seg0}, 8'b0000_0110);
    checkOutput("T2 repeat an", {6'h3f, an0}, 8'hfd);

    for (int i = 1; i <= 5; i++) begin
      applyStimulus(1, 1'b1, 4'(i), 1'b0);
      step();
    end
    applyStimulus(1, 1'b0, 4'h0, 1'b0);
    stepTo(60);
    checkOutput("T3 digit3 an", {4'hf, an1}, 8'hf7);
    checkOutput("T3 digit3 seg", {1'b0, seg1}, 8'b0001_0010);
    stepTo(68);
    checkOutput("T3 digit0 an", {4'hf, an1}, 8'hfe);
    checkOutput("T3 digit0 seg", {1'b0, seg1}, 8'b0010_0100);

    applyStimulus(1, 1'b1, 4'h7, 1'b1);
    step();
    applyStimulus(1, 1'b0, 4'h0, 1'b0);
    stepTo(92);
    checkOutput("T4 digit3 an", {4'hf, an1}, 8'hf7);
    checkOutput("T4 digit3 seg", {1'b0, seg1}, {1'b0, EMPTY});
    stepTo(100);
    checkOutput("T4 digit0 an", {4'hf, an1}, 8'hfe);
    checkOutput("T4 digit0 seg", {1'b0, seg1}, {1'b0, EMPTY});

    stepTo(101);
    for (int j = 0; j < 16; j++) begin
      applyStimulus(2, 1'b1, 4'(j), 1'b0);
      step();
      applyStimulus(2, 1'b0, 4'h0, 1'b0);
      step();
      checkOutput($sformatf("T5 code %0d seg", j), {1'b0, seg2}, {1'b0, DEC[j]});
      checkOutput($sformatf("T5 code %0d an", j), {7'h7f, an2}, 8'hfe);
      step();
      step();
    end

    stepTo(185);
    checkOutput("T6 before reset an", {6'h3f, an0}, 8'hfd);
    checkOutput("T6 before reset idx", {5'd0, si0}, 8'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    checkOutput("T6 reset an", {6'h3f, an0}, 8'hff);
    checkOutput("T6 reset idx", {5'd0, si0}, 8'd0);
    checkOutput("T6 reset dut1 an", {4'hf, an1}, 8'hff);
    step();
    step();
    checkOutput("T6 blank after reset", {6'h3f, an0}, 8'hff);
    step();
    checkOutput("T6 relit an", {6'h3f, an0}, 8'hfe);
    checkOutput("T6 relit seg", {1'b0, seg0}, {1'b0, EMPTY});
    repeat (64) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
